neighbor_select: RTL

//   Downstream of the RNG address stage. Takes the 0-based index rng_address, which is less than the

---
 rtl/neighbor_pkg.sv | 14 +
 rtl/neighbor_select_scan_counter.sv | 30 +++
 rtl/neighbor_select.sv | 118 +++++++++++
 3 files changed

// File: rtl/neighbor_pkg.sv
// Shared definitions for the neighbour-selection datapath: FSM encoding and the
// default widths also used by the RNG address stage.
package neighbor_pkg;

  localparam int DEF_COST_W = 16;
  localparam int DEF_IDX_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/neighbor_select_scan_counter.sv
// Cost-memory address counter: clears to 0, counts up while enabled and holds
// once it reaches LAST; terminal flags that the current address is LAST.
module scan_counter #(
  parameter int IDX_W = 16,
  parameter int LAST  = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] count,
  output logic             terminal
);

  logic [IDX_W-1:0] count_reg;

  assign count    = count_reg;
  assign terminal = (count_reg == IDX_W'(LAST));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !terminal) begin
      count_reg <= count_reg + IDX_W'(1);
    end
  end

endmodule

// File: rtl/neighbor_select.sv
// Scans the neighbour cost memory for the rng_address-th neighbour cheaper than
// current_cost. Define SELECT_EQUAL_EN to also accept equal-cost neighbours.
module neighbor_select
  import neighbor_pkg::*;
#(
  parameter int NUM_NEIGHBORS = 8,
  parameter int COST_W        = DEF_COST_W,
  parameter int IDX_W         = DEF_IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_select,
  input  logic [IDX_W-1:0]  rng_address,
  input  logic [COST_W-1:0] current_cost,
  output logic [IDX_W-1:0]  cost_addr,
  input  logic [COST_W-1:0] cost_data,
  output logic [IDX_W-1:0]  neighbor_index,
  output logic              found,
  output logic              done_select
);

  state_t            state_reg;
  logic [IDX_W-1:0]  target_reg;
  logic [COST_W-1:0] cur_cost_reg;
  logic [IDX_W-1:0]  better_cnt_reg;
  logic              rd_valid_reg;
  logic [IDX_W-1:0]  rd_idx_reg;
  logic              rd_last_reg;
  logic [IDX_W-1:0]  neighbor_index_reg;
  logic              found_reg;
  logic              done_reg;

  logic accept;
  logic addr_terminal;
  logic is_better;
  logic is_hit;

  assign accept = start_select && ((state_reg == IDLE) || (state_reg == DONE));

  scan_counter #(
    .IDX_W (IDX_W),
    .LAST  (NUM_NEIGHBORS - 1)
  ) u_scan_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept),
    .enable   (state_reg == SCAN),
    .count    (cost_addr),
    .terminal (addr_terminal)
  );

`ifdef SELECT_EQUAL_EN
  assign is_better = rd_valid_reg && (cost_data <= cur_cost_reg);
`else
  assign is_better = rd_valid_reg && (cost_data < cur_cost_reg);
`endif

  assign is_hit = is_better && (better_cnt_reg == target_reg);

  // rd_*_reg describe the address issued last cycle, i.e. the one cost_data now holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg          <= IDLE;
      target_reg         <= '0;
      cur_cost_reg       <= '0;
      better_cnt_reg     <= '0;
      rd_valid_reg       <= 1'b0;
      rd_idx_reg         <= '0;
      rd_last_reg        <= 1'b0;
      neighbor_index_reg <= '0;
      found_reg          <= 1'b0;
      done_reg           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start_select) begin
            target_reg     <= rng_address;
            cur_cost_reg   <= current_cost;
            better_cnt_reg <= '0;
            rd_valid_reg   <= 1'b0;
            rd_idx_reg     <= '0;
            rd_last_reg    <= 1'b0;
            found_reg      <= 1'b0;
            done_reg       <= 1'b0;
            state_reg      <= SCAN;
          end
        end
        SCAN: begin
          rd_valid_reg <= 1'b1;
          rd_idx_reg   <= cost_addr;
          rd_last_reg  <= addr_terminal;
          if (is_hit) begin
            neighbor_index_reg <= rd_idx_reg;
            found_reg          <= 1'b1;
            done_reg           <= 1'b1;
            state_reg          <= DONE;
          end else begin
            if (is_better) begin
              better_cnt_reg <= better_cnt_reg + IDX_W'(1);
            end
            if (rd_valid_reg && rd_last_reg) begin
              neighbor_index_reg <= '0;
              found_reg          <= 1'b0;
              done_reg           <= 1'b1;
              state_reg          <= DONE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign neighbor_index = neighbor_index_reg;
  assign found          = found_reg;
  assign done_select    = done_reg;

endmodule
